// File: rtl/rs_slot_alloc.sv
// Dispatch-side allocator for one reservation-station buffer.
// Tracks occupancy, grants up to three lowest free entries per cycle as
// one-hot write selects (plus group-of-8 hints), and returns issued entries
// through a one-cycle free pipeline. An exception flushes everything.
//
// Handshake: dispatch presents alloc_req (1..3) and holds it until alloc_ok
// is high in the same cycle; a grant is all-or-nothing and the granted
// entries are marked busy at the rising edge that ends the granting cycle.
module rs_slot_alloc #(
    parameter int BUF_COUNT = 32,
    parameter int GRP_COUNT = BUF_COUNT / 8,
    parameter int CNT_W     = $clog2(BUF_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 except,
    input  logic [1:0]           alloc_req,
    output logic                 alloc_ok,
    output logic [BUF_COUNT-1:0] alloc_slot0,
    output logic [BUF_COUNT-1:0] alloc_slot1,
    output logic [BUF_COUNT-1:0] alloc_slot2,
    output logic [GRP_COUNT-1:0] alloc_grp0,
    output logic [GRP_COUNT-1:0] alloc_grp1,
    output logic [GRP_COUNT-1:0] alloc_grp2,
    input  logic [BUF_COUNT-1:0] issue_sel0,
    input  logic [BUF_COUNT-1:0] issue_sel1,
    input  logic [BUF_COUNT-1:0] issue_sel2,
    output logic [BUF_COUNT-1:0] busy,
    output logic [CNT_W-1:0]     free_cnt,
    output logic                 almost_full,
    output logic                 err,
    output logic                 fsm_state
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [BUF_COUNT-1:0] ONE = BUF_COUNT'(1);

    state_t               state;
    state_t               state_next;
    logic [BUF_COUNT-1:0] free_pend;
    logic [BUF_COUNT-1:0] pick0;
    logic [BUF_COUNT-1:0] pick1;
    logic [BUF_COUNT-1:0] pick2;
    logic [1:0]           seen;
    logic [BUF_COUNT-1:0] grant_mask;
    logic [BUF_COUNT-1:0] issue_or;
    logic [BUF_COUNT-1:0] busy_next;
    logic [CNT_W-1:0]     req_ext;
    logic [CNT_W-1:0]     freed_n;
    logic [CNT_W-1:0]     cnt_next;
    logic                 proto_err;

    assign fsm_state = (state == FLUSH);

    // State register: RUN/FLUSH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // Next state: except always lands in FLUSH; FLUSH lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (except) state_next = FLUSH;
            FLUSH:   state_next = except ? FLUSH : RUN;
            default: state_next = RUN;
        endcase
    end

    // Pick the three lowest free entries; entries still pending free stay busy.
    always_comb begin
        pick0 = '0;
        pick1 = '0;
        pick2 = '0;
        seen  = 2'd0;
        for (int i = 0; i < BUF_COUNT; i++) begin
            if (!busy[i]) begin
                if (seen == 2'd0) begin
                    pick0[i] = 1'b1;
                    seen     = 2'd1;
                end else if (seen == 2'd1) begin
                    pick1[i] = 1'b1;
                    seen     = 2'd2;
                end else if (seen == 2'd2) begin
                    pick2[i] = 1'b1;
                    seen     = 2'd3;
                end
            end
        end
    end

    assign req_ext  = CNT_W'(alloc_req);
    assign alloc_ok = (state == RUN) & ~except & (alloc_req != 2'd0) & (free_cnt >= req_ext);

    assign alloc_slot0 = (alloc_ok && alloc_req >= 2'd1) ? pick0 : '0;
    assign alloc_slot1 = (alloc_ok && alloc_req >= 2'd2) ? pick1 : '0;
    assign alloc_slot2 = (alloc_ok && alloc_req == 2'd3) ? pick2 : '0;
    assign grant_mask  = alloc_slot0 | alloc_slot1 | alloc_slot2;

    for (genvar g = 0; g < GRP_COUNT; g++) begin : g_grp
        assign alloc_grp0[g] = |alloc_slot0[g*8 +: 8];
        assign alloc_grp1[g] = |alloc_slot1[g*8 +: 8];
        assign alloc_grp2[g] = |alloc_slot2[g*8 +: 8];
    end

    assign issue_or = issue_sel0 | issue_sel1 | issue_sel2;

    // Count entries actually released this edge (only bits that are still busy).
    always_comb begin
        freed_n = '0;
        for (int i = 0; i < BUF_COUNT; i++) begin
            if (free_pend[i] && busy[i]) freed_n = freed_n + CNT_W'(1);
        end
    end

    // Next occupancy and free count; except wipes both.
    always_comb begin
        busy_next = (busy & ~free_pend) | grant_mask;
        cnt_next  = free_cnt + freed_n - (alloc_ok ? req_ext : '0);
        if (except) begin
            busy_next = '0;
            cnt_next  = CNT_W'(BUF_COUNT);
        end
    end

    // Protocol checks on the issue selects.
    always_comb begin
        proto_err = 1'b0;
        if ((issue_or & ~busy) != '0) proto_err = 1'b1;
        if (((issue_sel0 & issue_sel1) | (issue_sel0 & issue_sel2) | (issue_sel1 & issue_sel2)) != '0)
            proto_err = 1'b1;
        if ((issue_sel0 & (issue_sel0 - ONE)) != '0) proto_err = 1'b1;
        if ((issue_sel1 & (issue_sel1 - ONE)) != '0) proto_err = 1'b1;
        if ((issue_sel2 & (issue_sel2 - ONE)) != '0) proto_err = 1'b1;
    end

    // Occupancy, free pipeline, counter, almost_full and sticky err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            free_pend   <= '0;
            free_cnt    <= CNT_W'(BUF_COUNT);
            almost_full <= 1'b0;
            err         <= 1'b0;
        end else begin
            busy        <= busy_next;
            free_pend   <= except ? '0 : issue_or;
            free_cnt    <= cnt_next;
            almost_full <= (cnt_next < CNT_W'(3));
            if (proto_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Bench for rs_slot_alloc: directed scenarios plus randomized traffic checked
// against an entry-list model of the reservation station.
module tb_rs_slot_alloc;

    localparam int BUF = 32;
    localparam int GRP = 4;
    localparam int CW  = 6;

    logic           clk;
    logic           rst;
    logic           except;
    logic [1:0]     alloc_req;
    logic           alloc_ok;
    logic [BUF-1:0] alloc_slot0, alloc_slot1, alloc_slot2;
    logic [GRP-1:0] alloc_grp0, alloc_grp1, alloc_grp2;
    logic [BUF-1:0] issue_sel0, issue_sel1, issue_sel2;
    logic [BUF-1:0] busy;
    logic [CW-1:0]  free_cnt;
    logic           almost_full;
    logic           err;
    logic           fsm_state;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: occupancy per entry, list of entries waiting to be freed.
    bit             occ[BUF];
    int             pend[$];
    bit             m_err;
    bit             m_flush;
    bit             exp_ok;
    logic [BUF-1:0] exp_slot[3];
    logic [GRP-1:0] exp_grp[3];
    int             exp_idx[3];
    logic [BUF-1:0] got_slot[3];
    logic [GRP-1:0] got_grp[3];

    rs_slot_alloc dut (
        .clk(clk), .rst(rst), .except(except), .alloc_req(alloc_req),
        .alloc_ok(alloc_ok),
        .alloc_slot0(alloc_slot0), .alloc_slot1(alloc_slot1), .alloc_slot2(alloc_slot2),
        .alloc_grp0(alloc_grp0), .alloc_grp1(alloc_grp1), .alloc_grp2(alloc_grp2),
        .issue_sel0(issue_sel0), .issue_sel1(issue_sel1), .issue_sel2(issue_sel2),
        .busy(busy), .free_cnt(free_cnt), .almost_full(almost_full), .err(err),
        .fsm_state(fsm_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    always_comb begin
        got_slot[0] = alloc_slot0;
        got_slot[1] = alloc_slot1;
        got_slot[2] = alloc_slot2;
        got_grp[0]  = alloc_grp0;
        got_grp[1]  = alloc_grp1;
        got_grp[2]  = alloc_grp2;
    end

    function automatic int free_count();
        int c = 0;
        for (int i = 0; i < BUF; i++) if (!occ[i]) c++;
        return c;
    endfunction

    function automatic logic [BUF-1:0] busy_vec();
        logic [BUF-1:0] v = '0;
        for (int i = 0; i < BUF; i++) v[i] = occ[i];
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < BUF; i++) occ[i] = 1'b0;
        pend.delete();
        m_err   = 1'b0;
        m_flush = 1'b0;
    endtask

    // Expected combinational outputs for the inputs currently driven.
    task automatic predict();
        int fl[$];
        int r;
        r = int'(alloc_req);
        for (int i = 0; i < BUF; i++) if (!occ[i]) fl.push_back(i);
        exp_ok = !m_flush && (except !== 1'b1) && r != 0 && fl.size() >= r;
        for (int k = 0; k < 3; k++) begin
            exp_slot[k] = '0;
            exp_grp[k]  = '0;
            exp_idx[k]  = -1;
            if (exp_ok && k < r) begin
                exp_idx[k]          = fl[k];
                exp_slot[k][fl[k]]  = 1'b1;
                exp_grp[k][fl[k]/8] = 1'b1;
            end
        end
    endtask

    // Apply one rising edge to the model using the inputs of the ending cycle.
    task automatic model_edge();
        logic [BUF-1:0] iss[3];
        iss[0] = issue_sel0;
        iss[1] = issue_sel1;
        iss[2] = issue_sel2;
        predict();
        for (int k = 0; k < 3; k++) begin
            if ($countones(iss[k]) > 1) m_err = 1'b1;
            for (int j = k + 1; j < 3; j++) if ((iss[k] & iss[j]) != '0) m_err = 1'b1;
            for (int i = 0; i < BUF; i++) if (iss[k][i] && !occ[i]) m_err = 1'b1;
        end
        if (except === 1'b1) begin
            for (int i = 0; i < BUF; i++) occ[i] = 1'b0;
            pend.delete();
            m_flush = 1'b1;
        end else begin
            m_flush = 1'b0;
            foreach (pend[p]) occ[pend[p]] = 1'b0;
            pend.delete();
            for (int k = 0; k < 3; k++) if (exp_idx[k] >= 0) occ[exp_idx[k]] = 1'b1;
            for (int i = 0; i < BUF; i++) if (iss[0][i] | iss[1][i] | iss[2][i]) pend.push_back(i);
        end
    endtask

    // Driver tasks.
    task automatic do_reset();
        rst        = 1'b0;
        except     = 1'b0;
        alloc_req  = 2'd0;
        issue_sel0 = '0;
        issue_sel1 = '0;
        issue_sel2 = '0;
        reset_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drive(input int req, input bit ex, input logic [BUF-1:0] a,
                         input logic [BUF-1:0] b, input logic [BUF-1:0] c);
        alloc_req  = 2'(req);
        except     = ex;
        issue_sel0 = a;
        issue_sel1 = b;
        issue_sel2 = c;
        predict();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (busy !== '0) begin n_bad++; $display("FAIL reset_busy got=%h want=0", busy); end
        n_vec++; if (free_cnt !== 6'd32) begin n_bad++; $display("FAIL reset_free_cnt got=%0d want=32", free_cnt); end
        n_vec++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_almost_full got=%b want=0", almost_full); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
        n_vec++; if (fsm_state !== 1'b0) begin n_bad++; $display("FAIL reset_state got=%b want=0", fsm_state); end
        drive(3, 0, '0, '0, '0);
        n_vec++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL first_ok got=%b want=1", alloc_ok); end
        n_vec++; if (alloc_slot0 !== 32'h1) begin n_bad++; $display("FAIL first_slot0 got=%h want=1", alloc_slot0); end
        n_vec++; if (alloc_slot1 !== 32'h2) begin n_bad++; $display("FAIL first_slot1 got=%h want=2", alloc_slot1); end
        n_vec++; if (alloc_slot2 !== 32'h4) begin n_bad++; $display("FAIL first_slot2 got=%h want=4", alloc_slot2); end
        n_vec++; if ({alloc_grp0, alloc_grp1, alloc_grp2} !== 12'h111) begin n_bad++; $display("FAIL first_grp got=%h want=111", {alloc_grp0, alloc_grp1, alloc_grp2}); end
        tick();
        n_vec++; if (busy !== 32'h7) begin n_bad++; $display("FAIL first_busy got=%h want=7", busy); end
        n_vec++; if (free_cnt !== 6'd29) begin n_bad++; $display("FAIL first_free_cnt got=%0d want=29", free_cnt); end
    endtask

    task automatic test_fill();
        for (int c = 0; c < 9; c++) begin
            drive(3, 0, '0, '0, '0);
            tick();
        end
        n_vec++; if (free_cnt !== 6'd2) begin n_bad++; $display("FAIL fill_cnt got=%0d want=2", free_cnt); end
        n_vec++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL fill_af got=%b want=1", almost_full); end
        drive(3, 0, '0, '0, '0);
        n_vec++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL fill_no_partial got=%b want=0", alloc_ok); end
        n_vec++; if (alloc_slot0 !== '0) begin n_bad++; $display("FAIL fill_slot0_zero got=%h want=0", alloc_slot0); end
        tick();
        n_vec++; if (busy !== 32'h3FFF_FFFF) begin n_bad++; $display("FAIL fill_busy_hold got=%h want=3fffffff", busy); end
        drive(2, 0, '0, '0, '0);
        n_vec++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL fill_last_ok got=%b want=1", alloc_ok); end
        n_vec++; if (alloc_slot0 !== 32'h4000_0000) begin n_bad++; $display("FAIL fill_slot0 got=%h want=40000000", alloc_slot0); end
        n_vec++; if (alloc_slot1 !== 32'h8000_0000) begin n_bad++; $display("FAIL fill_slot1 got=%h want=80000000", alloc_slot1); end
        n_vec++; if (alloc_slot2 !== '0) begin n_bad++; $display("FAIL fill_slot2 got=%h want=0", alloc_slot2); end
        n_vec++; if ({alloc_grp0, alloc_grp1, alloc_grp2} !== 12'h880) begin n_bad++; $display("FAIL fill_grp got=%h want=880", {alloc_grp0, alloc_grp1, alloc_grp2}); end
        tick();
        n_vec++; if (free_cnt !== 6'd0) begin n_bad++; $display("FAIL full_cnt got=%0d want=0", free_cnt); end
        n_vec++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL full_af got=%b want=1", almost_full); end
    endtask

    task automatic test_free_reuse();
        drive(1, 0, '0, 32'h20, '0);
        n_vec++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL reuse_t_ok got=%b want=0", alloc_ok); end
        tick();
        drive(1, 0, '0, '0, '0);
        n_vec++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL reuse_t1_ok got=%b want=0", alloc_ok); end
        n_vec++; if (busy[5] !== 1'b1) begin n_bad++; $display("FAIL reuse_t1_busy5 got=%b want=1", busy[5]); end
        tick();
        drive(1, 0, '0, '0, '0);
        n_vec++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL reuse_t2_ok got=%b want=1", alloc_ok); end
        n_vec++; if (alloc_slot0 !== 32'h20) begin n_bad++; $display("FAIL reuse_t2_slot0 got=%h want=20", alloc_slot0); end
        n_vec++; if (busy[5] !== 1'b0) begin n_bad++; $display("FAIL reuse_t2_busy5 got=%b want=0", busy[5]); end
        n_vec++; if (free_cnt !== 6'd1) begin n_bad++; $display("FAIL reuse_t2_cnt got=%0d want=1", free_cnt); end
        tick();
        n_vec++; if (busy !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reuse_refill got=%h want=ffffffff", busy); end
        n_vec++; if (free_cnt !== 6'd0) begin n_bad++; $display("FAIL reuse_refill_cnt got=%0d want=0", free_cnt); end
    endtask

    task automatic test_except();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(3, 0, '0, '0, '0);
            tick();
        end
        drive(2, 0, '0, '0, '0);
        tick();
        n_vec++; if (busy !== 32'h000F_FFFF) begin n_bad++; $display("FAIL exc_busy20 got=%h want=fffff", busy); end
        drive(0, 0, 32'h4, '0, '0);
        tick();
        drive(3, 1, '0, '0, '0);
        n_vec++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL exc_ok got=%b want=0", alloc_ok); end
        tick();
        drive(3, 0, '0, '0, '0);
        n_vec++; if (busy !== '0) begin n_bad++; $display("FAIL exc_busy got=%h want=0", busy); end
        n_vec++; if (free_cnt !== 6'd32) begin n_bad++; $display("FAIL exc_cnt got=%0d want=32", free_cnt); end
        n_vec++; if (fsm_state !== 1'b1) begin n_bad++; $display("FAIL exc_state got=%b want=1", fsm_state); end
        n_vec++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL exc_flush_ok got=%b want=0", alloc_ok); end
        tick();
        drive(3, 0, '0, '0, '0);
        n_vec++; if (fsm_state !== 1'b0) begin n_bad++; $display("FAIL exc_run_state got=%b want=0", fsm_state); end
        n_vec++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL exc_run_ok got=%b want=1", alloc_ok); end
        n_vec++; if (alloc_slot0 !== 32'h1) begin n_bad++; $display("FAIL exc_run_slot0 got=%h want=1", alloc_slot0); end
        tick();
        n_vec++; if (busy !== 32'h7) begin n_bad++; $display("FAIL exc_run_busy got=%h want=7", busy); end
    endtask

    task automatic test_err();
        do_reset();
        drive(0, 0, '0, '0, 32'h200);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pre got=%b want=0", err); end
        tick();
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b want=1", err); end
        for (int c = 0; c < 3; c++) begin
            drive(3, 0, '0, '0, '0);
            tick();
        end
        drive(0, 0, 32'h10, '0, '0);
        tick();
        drive(0, 0, '0, '0, '0);
        tick();
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b want=1", err); end
        n_vec++; if (busy !== 32'h1EF) begin n_bad++; $display("FAIL err_busy got=%h want=1ef", busy); end
        n_vec++; if (free_cnt !== 6'd24) begin n_bad++; $display("FAIL err_cnt got=%0d want=24", free_cnt); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL async_err got=%b want=0", err); end
        n_vec++; if (busy !== '0) begin n_bad++; $display("FAIL async_busy got=%h want=0", busy); end
        n_vec++; if (free_cnt !== 6'd32) begin n_bad++; $display("FAIL async_cnt got=%0d want=32", free_cnt); end
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(3, 0, '0, '0, '0);
            tick();
        end
        drive(0, 0, 32'h8, 32'h80, '0);
        tick();
        drive(2, 0, '0, '0, '0);
        n_vec++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL same_ok got=%b want=1", alloc_ok); end
        n_vec++; if (alloc_slot0 !== 32'h1000) begin n_bad++; $display("FAIL same_slot0 got=%h want=1000", alloc_slot0); end
        n_vec++; if (alloc_slot1 !== 32'h2000) begin n_bad++; $display("FAIL same_slot1 got=%h want=2000", alloc_slot1); end
        tick();
        n_vec++; if (free_cnt !== 6'd20) begin n_bad++; $display("FAIL same_cnt got=%0d want=20", free_cnt); end
        n_vec++; if (busy !== 32'h3F77) begin n_bad++; $display("FAIL same_busy got=%h want=3f77", busy); end
    endtask

    task automatic test_random();
        logic [BUF-1:0] iss[3];
        bit             used[BUF];
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < BUF; i++) used[i] = 1'b0;
            foreach (pend[p]) used[pend[p]] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                iss[k] = '0;
                if ($urandom_range(0, 1) == 1) begin
                    for (int t = 0; t < 6; t++) begin
                        int c;
                        c = $urandom_range(0, BUF - 1);
                        if (occ[c] && !used[c]) begin
                            iss[k][c] = 1'b1;
                            used[c]   = 1'b1;
                            break;
                        end
                    end
                end
            end
            drive(int'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0), iss[0], iss[1], iss[2]);
            n_vec++; if (alloc_ok !== exp_ok) begin n_bad++; $display("FAIL rnd_ok cyc=%0d got=%b want=%b", cyc, alloc_ok, exp_ok); end
            for (int k = 0; k < 3; k++) begin
                n_vec++; if (got_slot[k] !== exp_slot[k]) begin n_bad++; $display("FAIL rnd_slot%0d cyc=%0d got=%h want=%h", k, cyc, got_slot[k], exp_slot[k]); end
                n_vec++; if (got_grp[k] !== exp_grp[k]) begin n_bad++; $display("FAIL rnd_grp%0d cyc=%0d got=%h want=%h", k, cyc, got_grp[k], exp_grp[k]); end
            end
            tick();
            n_vec++; if (busy !== busy_vec()) begin n_bad++; $display("FAIL rnd_busy cyc=%0d got=%h want=%h", cyc, busy, busy_vec()); end
            n_vec++; if (free_cnt !== CW'(free_count())) begin n_bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", cyc, free_cnt, free_count()); end
            n_vec++; if (almost_full !== (free_count() < 3)) begin n_bad++; $display("FAIL rnd_af cyc=%0d got=%b want=%b", cyc, almost_full, free_count() < 3); end
            n_vec++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", cyc, err, m_err); end
            n_vec++; if (fsm_state !== m_flush) begin n_bad++; $display("FAIL rnd_state cyc=%0d got=%b want=%b", cyc, fsm_state, m_flush); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_free_reuse();
        test_except();
        test_err();
        test_same_cycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_slot_alloc.md
Name: rs_slot_alloc

Overview:
Dispatch-side writer for one 32-entry reservation-station buffer. It is the counterpart of the per-port ready/select FIFO logic that reads the buffer. It tracks which entries are occupied and hands up to three free entries per cycle to the dispatch stage as one-hot write selects, with group-of-8 hints. Entries issued by the select ports are returned through a one-cycle free pipeline; an exception flushes the buffer.

Parameters:
BUF_COUNT, 32, number of RS entries; must be a multiple of 8.
GRP_COUNT, BUF_COUNT/8, number of 8-entry groups used for the write-select hints.
CNT_W, 6, free-counter width, equal to clog2(BUF_COUNT+1).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
except  in  1  synchronous flush of all entries.
alloc_req  in  2  number of entries dispatch wants this cycle (0..3).
alloc_ok  out  1  request granted this cycle (combinational).
alloc_slot0/1/2  out  BUF_COUNT each  one-hot write select per granted entry.
alloc_grp0/1/2  out  GRP_COUNT each  one-hot group of the matching slot.
issue_sel0/1/2  in  BUF_COUNT each  one-hot (or zero) issue select from the three select ports.
busy  out  BUF_COUNT  occupancy vector, registered.
free_cnt  out  CNT_W  number of free entries, registered.
almost_full  out  1  asserted when free_cnt<3, registered.
err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, asynchronous): busy=0, free_pend=0, free_cnt=BUF_COUNT, almost_full=0, err=0, state=RUN.
- State machine, 2 states:
  - RUN to FLUSH on except.
  - FLUSH to RUN unconditionally after 1 cycle.
  - FLUSH forces alloc_ok=0.
- Slot choice, combinational from ~busy:
  - slot0 is the lowest free index, slot1 the next lowest, slot2 the next.
  - A slot is zero if no such free entry exists.
  - alloc_grpK is the one-hot of (index of slotK)/8, or zero if slotK is zero.
- Grant rule: alloc_ok = (state==RUN) & ~except & (alloc_req!=0) & (free_cnt>=alloc_req).
  - Only slots 0..alloc_req-1 are valid; higher slots are driven to 0.
  - There is no partial grant: a request either receives all alloc_req entries or none.
  - When alloc_ok=0, all slot and group outputs are 0.
  - Dispatch must hold alloc_req until it sees alloc_ok.
- Allocation latency: granted bits are set in busy at the same rising edge as the grant.
- Free pipeline:
  - Edge t+1: free_pend <= issue_sel0|issue_sel1|issue_sel2 (sampled in cycle t).
  - Edge t+2: busy &= ~free_pend.
  - An issued entry is allocatable no earlier than cycle t+2, so there is no same-cycle or next-cycle reuse.
- Counter: free_cnt <= free_cnt + popcount(free_pend) - (alloc_ok ? alloc_req : 0).
  - This must always equal popcount(~busy) after the edge.
  - Arithmetic is CNT_W bits and must never wrap.
- Simultaneous events:
  - A free and an allocation in the same cycle apply together.
  - An entry being cleared by free_pend is not visible as free until the edge after.
- except, synchronous, has highest priority:
  - busy<=0, free_pend<=0, free_cnt<=BUF_COUNT.
  - Any concurrent grant and any issue_sel are discarded.
  - state<=FLUSH.
- err is set sticky (cleared only by rst) when any of the following occurs:
  - an issue_sel bit hits an entry with busy=0;
  - two issue_sel vectors share a bit;
  - an issue_sel vector has more than one bit set.
  - err does not alter busy handling.
- almost_full is recomputed from the next-state free_cnt.

Test Plan:
1. After reset, alloc_req=3 -> alloc_ok=1, slot0=0x1, slot1=0x2, slot2=0x4, grp0..2=0x1; next cycle busy=0x7, free_cnt=29.
2. Allocate 3/cycle for 10 cycles (30 busy); then alloc_req=3 -> alloc_ok=0, busy unchanged; then alloc_req=2 -> slot0=bit30, slot1=bit31, grp=0x8; free_cnt=0, almost_full=1.
3. Buffer full, issue_sel1=bit5 in cycle t, alloc_req=1 held -> alloc_ok=0 in t and t+1; in t+2 alloc_ok=1 with slot0=bit5; busy[5] is 0 only during t+2.
4. Buffer 20 busy, issue_sel0=bit2 pending in free_pend, alloc_req=3 with except=1 -> alloc_ok=0; next cycle busy=0, free_cnt=32, state FLUSH so alloc_ok=0; following cycle alloc_ok=1, slot0=bit0.
5. issue_sel2=bit9 while busy[9]=0 -> err=1 and remains 1 through later traffic until rst=0; async reset mid-cycle clears everything without a clock edge.
6. Steady state with 2 frees in free_pend and alloc_req=2 granted in the same cycle -> free_cnt unchanged, busy equals old busy minus the freed bits plus the granted bits.
